// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin using a single shared full-subtractor cell.
// Operands are shifted LSB-first; the borrow is carried in a flop between bits.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             cell_d;
  logic             cell_b;
  logic             last;

  assign cell_d = a_q[0] ^ b_q[0] ^ brw_q;
  assign cell_b = (~a_q[0] & b_q[0])
                | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // A 1-bit result register has nothing to shift down.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_d = cell_d;
    end else begin : g_wn
      assign res_d = {cell_d, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            brw_q   <= bin_in;
            a_msb_q <= a_in[WIDTH-1];
            b_msb_q <= b_in[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          brw_q <= cell_b;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            diff_q  <= res_d;
            bout_q  <= cell_b;
            ovf_q   <= (a_msb_q != b_msb_q)
                    && (res_d[WIDTH-1] != a_msb_q);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff_out = diff_q;
  assign bout     = bout_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: W=8 and W=1 instances against a
// timeline/arithmetic model, plus directed literal cases.
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rs [2];
  logic       st [2];
  logic [7:0] av [2];
  logic [7:0] bv [2];
  logic       bi [2];

  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic       busy1, done1, bout1, ovf1;
  logic [0:0] diff1;

  logic       ob  [2];
  logic       od  [2];
  logic [7:0] odf [2];
  logic       obo [2];
  logic       oov [2];

  int errs   = 0;
  int checks = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rs[0]), .start(st[0]),
    .a_in(av[0]), .b_in(bv[0]), .bin_in(bi[0]),
    .busy(busy8), .done(done8), .diff_out(diff8),
    .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_d1 (
    .clk(clk), .rst(rs[1]), .start(st[1]),
    .a_in(av[1][0:0]), .b_in(bv[1][0:0]), .bin_in(bi[1]),
    .busy(busy1), .done(done1), .diff_out(diff1),
    .bout(bout1), .ovf(ovf1)
  );

  assign ob[0]  = busy8;
  assign od[0]  = done8;
  assign odf[0] = diff8;
  assign obo[0] = bout8;
  assign oov[0] = ovf8;
  assign ob[1]  = busy1;
  assign od[1]  = done1;
  assign odf[1] = {7'b0, diff1};
  assign obo[1] = bout1;
  assign oov[1] = ovf1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h",
               nm, i, $time, got, exp);
    end
  endtask

  // Reference arithmetic straight from the definition of a - b - bin.
  function automatic void ref_sub(input int w,
                                  input longint a, input longint b,
                                  input bit bn,
                                  output logic [7:0] d,
                                  output bit bo, output bit ov);
    longint m, r, sa, sb, sr;
    m  = longint'(1) << w;
    r  = a - b - bn;
    d  = 8'(r & (m - 1));
    bo = (a < b + bn);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = sa - sb - bn;
    ov = (sr < -(m / 2)) || (sr > m / 2 - 1);
  endfunction

  // Timeline model: accept edge e -> results at e+W, idle after e+W+1.
  bit         act [2];
  longint     fire[2];
  longint     ma  [2];
  longint     mb  [2];
  bit         mbn [2];
  bit         eb  [2];
  bit         ed  [2];
  logic [7:0] edf [2];
  bit         ebo [2];
  bit         eov [2];

  initial begin
    longint e;
    int w;
    e = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; eb[i] = 0; ed[i] = 0;
      edf[i] = 0; ebo[i] = 0; eov[i] = 0;
    end
    forever begin
      @(posedge clk);
      e++;
      for (int i = 0; i < 2; i++) begin
        w = (i == 0) ? 8 : 1;
        ed[i] = 0;
        if (rs[i]) begin
          act[i] = 0; eb[i] = 0;
          edf[i] = 0; ebo[i] = 0; eov[i] = 0;
        end else if (!act[i]) begin
          if (st[i]) begin
            act[i]  = 1;
            eb[i]   = 1;
            fire[i] = e + w;
            ma[i]   = av[i] & ((i == 0) ? 8'hFF : 8'h01);
            mb[i]   = bv[i] & ((i == 0) ? 8'hFF : 8'h01);
            mbn[i]  = bi[i];
          end
        end else if (e == fire[i]) begin
          ref_sub(w, ma[i], mb[i], mbn[i],
                  edf[i], ebo[i], eov[i]);
          ed[i] = 1;
        end else if (e == fire[i] + 1) begin
          act[i] = 0;
          eb[i]  = 0;
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, ob[i], eb[i]);
        chk("done", i, od[i], ed[i]);
        chk("diff", i, odf[i], edf[i]);
        chk("bout", i, obo[i], ebo[i]);
        chk("ovf",  i, oov[i], eov[i]);
      end
    end
  end

  // One directed op: literal results plus busy-cycle count.
  task automatic op(input int i, input string nm,
                    input logic [7:0] a, input logic [7:0] b,
                    input bit bn, input logic [7:0] xd,
                    input bit xb, input bit xo, input int xbusy);
    int bc;
    bit seen;
    logic [7:0] gd;
    bit gb, go;
    bc = 0; seen = 0; gd = 0; gb = 0; go = 0;
    @(negedge clk);
    av[i] = a; bv[i] = b; bi[i] = bn; st[i] = 1;
    @(negedge clk);
    st[i] = 0;
    av[i] = 8'($urandom);
    bv[i] = 8'($urandom);
    bi[i] = 1'($urandom);
    for (int k = 0; k < 30; k++) begin
      if (ob[i]) bc++;
      if (od[i]) begin
        seen = 1; gd = odf[i]; gb = obo[i]; go = oov[i];
      end
      @(negedge clk);
    end
    chk({nm, "_seen"}, i, seen, 1);
    chk({nm, "_diff"}, i, gd, xd);
    chk({nm, "_bout"}, i, gb, xb);
    chk({nm, "_ovf"},  i, go, xo);
    chk({nm, "_busy"}, i, bc, xbusy);
  endtask

  initial begin
    int t1, t2, nd, nq;
    logic [7:0] d1v, d2v;
    for (int i = 0; i < 2; i++) begin
      rs[i] = 1; st[i] = 0; av[i] = 0; bv[i] = 0; bi[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, ob[0], 0);
    chk("rst_diff", 0, odf[0], 0);
    rs[0] = 0; rs[1] = 0;

    op(0, "t1",  8'h5A, 8'h3C, 0, 8'h1E, 0, 0, 9);
    op(0, "t2a", 8'h00, 8'h01, 0, 8'hFF, 1, 0, 9);
    op(0, "t2b", 8'h10, 8'h0F, 1, 8'h00, 0, 0, 9);
    op(0, "t3a", 8'h80, 8'h01, 0, 8'h7F, 0, 1, 9);
    op(0, "t3b", 8'h7F, 8'hFF, 0, 8'h80, 1, 1, 9);

    // start held high: back-to-back ops, extra starts ignored
    @(negedge clk);
    av[0] = 8'h05; bv[0] = 8'h03; bi[0] = 0; st[0] = 1;
    nq = 0; t1 = 0; t2 = 0; d1v = 0; d2v = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (od[0]) begin
        if (nq == 0) begin
          t1 = k; d1v = odf[0];
          av[0] = 8'h03; bv[0] = 8'h05;
        end else begin
          t2 = k; d2v = odf[0];
        end
        nq++;
      end
    end
    st[0] = 0;
    chk("t4_count", 0, nq, 2);
    chk("t4_gap",   0, t2 - t1, 10);
    chk("t4_d1",    0, d1v, 8'h02);
    chk("t4_d2",    0, d2v, 8'hFE);
    repeat (15) @(negedge clk);

    // reset in the 4th SHIFT cycle
    @(negedge clk);
    av[0] = 8'h33; bv[0] = 8'h11; bi[0] = 0; st[0] = 1;
    @(negedge clk);
    st[0] = 0;
    repeat (3) @(negedge clk);
    rs[0] = 1;
    @(negedge clk);
    rs[0] = 0;
    chk("t5_busy", 0, ob[0], 0);
    chk("t5_diff", 0, odf[0], 0);
    chk("t5_bout", 0, obo[0], 0);
    nq = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (od[0]) nq++;
    end
    chk("t5_nodone", 0, nq, 0);
    op(0, "t5c", 8'h33, 8'h11, 0, 8'h22, 0, 0, 9);

    // rst and start together: rst wins
    @(negedge clk);
    rs[0] = 1; st[0] = 1;
    @(negedge clk);
    rs[0] = 0; st[0] = 0;
    @(negedge clk);
    chk("rs_st_busy", 0, ob[0], 0);

    op(1, "t6", 8'h00, 8'h01, 1, 8'h00, 1, 0, 2);

    // random sweep on both widths
    nd = 0;
    for (int c = 0; c < 20000 && nd < 1000; c++) begin
      @(negedge clk);
      if (od[0]) nd++;
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 3) != 0);
        av[i] = 8'($urandom);
        bv[i] = 8'($urandom);
        bi[i] = 1'($urandom);
        rs[i] = ($urandom_range(0, 299) == 0);
      end
    end
    chk("sweep_ops", 0, nd >= 1000, 1);
    for (int i = 0; i < 2; i++) begin
      rs[i] = 0; st[i] = 0;
    end
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
